// File: rtl/multi_counter_pkg.sv
// multi_counter_pkg
//   Shared types and defaults for the multi_counter bank.
//   mode_e    : per-channel terminal behaviour (WRAP / SAT)
//   DEFAULT_* : default WIDTH / NUM_CH used by the top level
//   ch_slice  : LSB index of channel `ch` inside a packed NUM_CH*WIDTH bus
package multi_counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_NUM_CH = 4;

    function automatic int ch_slice(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/multi_counter_channel.sv
// counter_channel
//   One counter channel: count/limit/mode registers, step logic and the
//   sticky ovf/udf flags. term_evt is the combinational terminal event of
//   the step taken this cycle; the top registers it into tc and, in the
//   cascaded build, chains it into the next channel's step enable.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     step_en         count step request (already gated by cascade, if any)
//     up_dn           1 = up, 0 = down
//     load, load_data synchronous load (clamped to the current limit)
//     cfg_wr          write cfg_limit / cfg_mode into this channel
//     ovf_clr         clears both sticky flags (a same-cycle set wins)
//     count, ovf, udf registered state
//     term_evt        combinational terminal event
module counter_channel
    import multi_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             cfg_wr,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             cfg_mode,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             udf,
    output logic             term_evt
);

    logic [WIDTH-1:0] limit;
    mode_e            mode;
    logic [WIDTH-1:0] count_nxt;
    logic             ovf_evt;
    logic             udf_evt;

    always_comb begin
        count_nxt = count;
        ovf_evt   = 1'b0;
        udf_evt   = 1'b0;
        if (load) begin
            count_nxt = (load_data > limit) ? limit : load_data;
        end else if (step_en) begin
            if (up_dn) begin
                if (count < limit) begin
                    count_nxt = count + WIDTH'(1);
                end else begin
                    ovf_evt   = 1'b1;
                    count_nxt = (mode == MODE_SAT) ? limit : '0;
                end
            end else begin
                // Above-limit counts (after a limit was lowered) are only
                // clamped on a down step; that is not a terminal event.
                if (count > limit) begin
                    count_nxt = limit;
                end else if (count == '0) begin
                    udf_evt   = 1'b1;
                    count_nxt = (mode == MODE_SAT) ? '0 : limit;
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end
        end
        term_evt = ovf_evt | udf_evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
            limit <= '1;
            mode  <= MODE_WRAP;
        end else begin
            count <= count_nxt;
            ovf   <= ovf_evt | (ovf & ~ovf_clr);
            udf   <= udf_evt | (udf & ~ovf_clr);
            if (cfg_wr) begin
                limit <= cfg_limit;
                mode  <= mode_e'(cfg_mode);
            end
        end
    end

endmodule

// File: rtl/multi_counter.sv
// multi_counter
//   Bank of NUM_CH independent up/down counters sharing WIDTH, with
//   per-channel modulo limit, WRAP/SAT mode, registered one-cycle tc and
//   sticky ovf/udf flags. Configuration is written one channel at a time.
//   Optional build macro: MULTI_COUNTER_CASCADE_EN -- channel i (i>=1) only
//   steps when en[i] is set and channel i-1 has a terminal event in the
//   same cycle (zero-latency chain). Undefined: channels are independent.
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     en, up_dn, load, ovf_clr      per-channel controls (NUM_CH bits)
//     load_data                     channel i at [i*WIDTH +: WIDTH]
//     cfg_we, cfg_ch, cfg_limit,
//     cfg_mode                      configuration write port
//     count                         current counts, same packing as load_data
//     tc, ovf, udf                  per-channel status
module multi_counter
    import multi_counter_pkg::*;
#(
    parameter  int WIDTH  = DEFAULT_WIDTH,
    parameter  int NUM_CH = DEFAULT_NUM_CH,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       up_dn,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] load_data,
    input  logic                    cfg_we,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [WIDTH-1:0]        cfg_limit,
    input  logic                    cfg_mode,
    input  logic [NUM_CH-1:0]       ovf_clr,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       tc,
    output logic [NUM_CH-1:0]       ovf,
    output logic [NUM_CH-1:0]       udf
);

    logic [NUM_CH-1:0] step_en;
    logic [NUM_CH-1:0] term_evt;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic cfg_wr;

        // Exact compare against each channel index: any cfg_ch value that
        // matches no channel simply writes nothing.
        assign cfg_wr = cfg_we && (cfg_ch == CH_W'(i));

`ifdef MULTI_COUNTER_CASCADE_EN
        if (i == 0) begin : g_head
            assign step_en[i] = en[i];
        end else begin : g_link
            assign step_en[i] = en[i] & term_evt[i-1];
        end
`else
        assign step_en[i] = en[i];
`endif

        counter_channel #(
            .WIDTH (WIDTH)
        ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .step_en   (step_en[i]),
            .up_dn     (up_dn[i]),
            .load      (load[i]),
            .load_data (load_data[ch_slice(i, WIDTH) +: WIDTH]),
            .cfg_wr    (cfg_wr),
            .cfg_limit (cfg_limit),
            .cfg_mode  (cfg_mode),
            .ovf_clr   (ovf_clr[i]),
            .count     (count[ch_slice(i, WIDTH) +: WIDTH]),
            .ovf       (ovf[i]),
            .udf       (udf[i]),
            .term_evt  (term_evt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tc <= '0;
        end else begin
            tc <= term_evt;
        end
    end

endmodule

// File: tb/tb_multi_counter.sv
module tb_multi_counter;

    localparam int WIDTH  = 8;
    localparam int NUM_CH = 5;
    localparam int CH_W   = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       en, up_dn, load, ovf_clr;
    logic [NUM_CH*WIDTH-1:0] load_data;
    logic                    cfg_we;
    logic [CH_W-1:0]         cfg_ch;
    logic [WIDTH-1:0]        cfg_limit;
    logic                    cfg_mode;
    logic [NUM_CH*WIDTH-1:0] count;
    logic [NUM_CH-1:0]       tc, ovf, udf;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_count [NUM_CH];
    int m_limit [NUM_CH];
    int m_mode  [NUM_CH];
    bit m_tc    [NUM_CH];
    bit m_ovf   [NUM_CH];
    bit m_udf   [NUM_CH];

    always #5 clk = ~clk;

    multi_counter #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_data(load_data), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_limit(cfg_limit), .cfg_mode(cfg_mode), .ovf_clr(ovf_clr),
        .count(count), .tc(tc), .ovf(ovf), .udf(udf)
    );

    function automatic int dut_cnt(input int ch);
        return int'(count[ch*WIDTH +: WIDTH]);
    endfunction

    function automatic logic [NUM_CH*WIDTH-1:0] exp_count();
        logic [NUM_CH*WIDTH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i*WIDTH +: WIDTH] = WIDTH'(m_count[i]);
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_tc();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = m_tc[i];
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_ovf();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = m_ovf[i];
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_udf();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = m_udf[i];
        return v;
    endfunction

    // Applies the behavioural rules to the inputs present at this edge.
    task automatic model_step();
        bit evt [NUM_CH];
        for (int i = 0; i < NUM_CH; i++) begin
            int c, lim, nc, ld;
            bit step, set_o, set_u;
            c = m_count[i]; lim = m_limit[i]; nc = c;
            set_o = 0; set_u = 0;
            ld = int'(load_data[i*WIDTH +: WIDTH]);
            step = en[i];
`ifdef MULTI_COUNTER_CASCADE_EN
            if (i > 0) step = step && evt[i-1];
`endif
            if (load[i]) nc = (ld > lim) ? lim : ld;
            else if (step) begin
                if (up_dn[i]) begin
                    if (c < lim) nc = c + 1;
                    else begin set_o = 1; nc = (m_mode[i] == 1) ? lim : 0; end
                end else begin
                    if (c > lim) nc = lim;
                    else if (c == 0) begin set_u = 1; nc = (m_mode[i] == 1) ? 0 : lim; end
                    else nc = c - 1;
                end
            end
            evt[i] = set_o || set_u;
            if (rst) begin
                m_count[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
                m_limit[i] = (1 << WIDTH) - 1; m_mode[i] = 0;
            end else begin
                m_count[i] = nc;
                m_tc[i]    = evt[i];
                m_ovf[i]   = set_o || (m_ovf[i] && !ovf_clr[i]);
                m_udf[i]   = set_u || (m_udf[i] && !ovf_clr[i]);
                if (cfg_we && int'(cfg_ch) == i) begin
                    m_limit[i] = int'(cfg_limit);
                    m_mode[i]  = int'(cfg_mode);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        rst = 0; en = '0; up_dn = '0; load = '0; load_data = '0; ovf_clr = '0;
        cfg_we = 0; cfg_ch = '0; cfg_limit = '0; cfg_mode = 0;
    endtask

    task automatic cfg_write(input int ch, input int lim, input bit mode);
        cfg_we = 1; cfg_ch = CH_W'(ch); cfg_limit = WIDTH'(lim); cfg_mode = mode;
    endtask

    task automatic test_reset();
        idle(); rst = 1; tick(); rst = 0;
        cfg_write(1, 0, 0); tick(); idle();
        en[1] = 1; up_dn[1] = 1; tick(); idle();
        n_tests++;
        if (tc[1] !== 1'b1 || ovf[1] !== 1'b1) begin
            n_fail++; $display("FAIL reset_pre_flag tc=%b ovf=%b required 1 1", tc[1], ovf[1]);
        end
        load[0] = 1; load_data[7:0] = 8'h35; tick(); idle();
        en[0] = 1; up_dn[0] = 1; tick(); tick(); idle();
        n_tests++;
        if (dut_cnt(0) !== 'h37) begin
            n_fail++; $display("FAIL reset_midcount count0=%0h required 37", dut_cnt(0));
        end
        rst = 1; en = '1; up_dn = '1; load[0] = 1; load_data[7:0] = 8'h80;
        cfg_write(0, 5, 1); tick(); tick(); idle();
        n_tests++;
        if (count !== '0 || tc !== '0 || ovf !== '0 || udf !== '0) begin
            n_fail++; $display("FAIL reset_state count=%h tc=%b ovf=%b udf=%b required all 0", count, tc, ovf, udf);
        end
        load[0] = 1; load_data[7:0] = 8'd254; tick(); idle();
        en[0] = 1; up_dn[0] = 1; tick();
        n_tests++;
        if (dut_cnt(0) !== 255 || tc[0] !== 1'b0) begin
            n_fail++; $display("FAIL reset_limit_ff count0=%0d tc=%b required 255 0", dut_cnt(0), tc[0]);
        end
        tick(); idle();
        n_tests++;
        if (dut_cnt(0) !== 0 || tc[0] !== 1'b1 || ovf[0] !== 1'b1) begin
            n_fail++; $display("FAIL reset_wrap_255 count0=%0d tc=%b ovf=%b required 0 1 1", dut_cnt(0), tc[0], ovf[0]);
        end
    endtask

    task automatic test_wrap_up();
        int n_tc = 0;
        idle(); cfg_write(0, 9, 0); load[0] = 1; load_data[7:0] = 8'd0; ovf_clr[0] = 1; tick(); idle();
        n_tests++;
        if (ovf[0] !== 1'b0 || dut_cnt(0) !== 0) begin
            n_fail++; $display("FAIL wrap_setup ovf=%b count0=%0d required 0 0", ovf[0], dut_cnt(0));
        end
        en[0] = 1; up_dn[0] = 1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (tc[0] === 1'b1) n_tc++;
            n_tests++;
            if (dut_cnt(0) !== (k + 1) % 10 || tc[0] !== (k == 9)) begin
                n_fail++; $display("FAIL wrap_step%0d count0=%0d tc=%b required %0d %b", k, dut_cnt(0), tc[0], (k + 1) % 10, k == 9);
            end
        end
        idle();
        n_tests++;
        if (n_tc != 1 || ovf[0] !== 1'b1) begin
            n_fail++; $display("FAIL wrap_summary tc_pulses=%0d ovf=%b required 1 1", n_tc, ovf[0]);
        end
    endtask

    task automatic test_sat_down();
        int exp_c [4] = '{1, 0, 0, 0};
        bit exp_t [4] = '{0, 0, 1, 1};
        idle(); cfg_write(1, 255, 1); ovf_clr[1] = 1; tick(); idle();
        load[1] = 1; load_data[15:8] = 8'd2; tick(); idle();
        en[1] = 1; up_dn[1] = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if (dut_cnt(1) !== exp_c[k] || tc[1] !== exp_t[k]) begin
                n_fail++; $display("FAIL sat_down%0d count1=%0d tc=%b required %0d %b", k, dut_cnt(1), tc[1], exp_c[k], exp_t[k]);
            end
        end
        n_tests++;
        if (udf[1] !== 1'b1 || ovf[1] !== 1'b0) begin
            n_fail++; $display("FAIL sat_udf udf=%b ovf=%b required 1 0", udf[1], ovf[1]);
        end
        ovf_clr[1] = 1; tick();
        n_tests++;
        if (udf[1] !== 1'b1 || tc[1] !== 1'b1) begin
            n_fail++; $display("FAIL clr_vs_set udf=%b tc=%b required 1 1", udf[1], tc[1]);
        end
        en[1] = 0; tick(); idle();
        n_tests++;
        if (udf[1] !== 1'b0 || tc[1] !== 1'b0) begin
            n_fail++; $display("FAIL clr_only udf=%b tc=%b required 0 0", udf[1], tc[1]);
        end
    endtask

    task automatic test_load_clamp();
        idle(); cfg_write(2, 20, 0); tick(); idle();
        load[2] = 1; load_data[23:16] = 8'd50; en[2] = 1; up_dn[2] = 1; tick(); idle();
        n_tests++;
        if (dut_cnt(2) !== 20 || tc[2] !== 1'b0) begin
            n_fail++; $display("FAIL load_clamp count2=%0d tc=%b required 20 0", dut_cnt(2), tc[2]);
        end
        en[2] = 1; up_dn[2] = 1; tick(); idle();
        n_tests++;
        if (dut_cnt(2) !== 0 || tc[2] !== 1'b1 || ovf[2] !== 1'b1) begin
            n_fail++; $display("FAIL load_then_wrap count2=%0d tc=%b ovf=%b required 0 1 1", dut_cnt(2), tc[2], ovf[2]);
        end
    endtask

    task automatic test_cfg_race();
        idle(); load[3] = 1; load_data[31:24] = 8'd5; tick(); idle();
        cfg_write(3, 3, 0); en[3] = 1; up_dn[3] = 1; tick(); idle();
        n_tests++;
        if (dut_cnt(3) !== 6 || tc[3] !== 1'b0) begin
            n_fail++; $display("FAIL cfg_race_old_limit count3=%0d tc=%b required 6 0", dut_cnt(3), tc[3]);
        end
        en[3] = 1; up_dn[3] = 1; tick(); idle();
        n_tests++;
        if (dut_cnt(3) !== 0 || tc[3] !== 1'b1 || ovf[3] !== 1'b1) begin
            n_fail++; $display("FAIL cfg_race_new_limit count3=%0d tc=%b ovf=%b required 0 1 1", dut_cnt(3), tc[3], ovf[3]);
        end
        for (int ch = NUM_CH; ch < 8; ch++) begin
            cfg_write(ch, 0, 1); tick();
        end
        idle(); en[3] = 1; en[4] = 1; up_dn[3] = 1; up_dn[4] = 1; tick(); idle();
        n_tests++;
        if (dut_cnt(3) !== 1 || dut_cnt(4) !== 1 || tc[4:3] !== 2'b00) begin
            n_fail++; $display("FAIL cfg_out_of_range count3=%0d count4=%0d tc=%b required 1 1 00", dut_cnt(3), dut_cnt(4), tc[4:3]);
        end
    endtask

    task automatic test_limit_zero();
        idle(); cfg_write(4, 0, 0); tick(); idle();
        en[4] = 1; up_dn[4] = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (dut_cnt(4) !== 0 || tc[4] !== 1'b1) begin
                n_fail++; $display("FAIL limit0_up%0d count4=%0d tc=%b required 0 1", k, dut_cnt(4), tc[4]);
            end
        end
        up_dn[4] = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_tests++;
            if (dut_cnt(4) !== 0 || tc[4] !== 1'b1 || udf[4] !== 1'b1) begin
                n_fail++; $display("FAIL limit0_down%0d count4=%0d tc=%b udf=%b required 0 1 1", k, dut_cnt(4), tc[4], udf[4]);
            end
        end
        idle();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst       = ($urandom_range(0, 63) == 0);
            en        = NUM_CH'($urandom);
            up_dn     = NUM_CH'($urandom);
            load      = NUM_CH'($urandom & $urandom & $urandom);
            ovf_clr   = NUM_CH'($urandom & $urandom);
            load_data = {$urandom, $urandom};
            cfg_we    = ($urandom_range(0, 3) == 0);
            cfg_ch    = CH_W'($urandom_range(0, 7));
            cfg_limit = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 15));
            cfg_mode  = 1'($urandom);
            tick();
            n_tests++;
            if (count !== exp_count() || tc !== exp_tc() || ovf !== exp_ovf() || udf !== exp_udf()) begin
                n_fail++;
                $display("FAIL random_cyc%0d count=%h tc=%b ovf=%b udf=%b required %h %b %b %b",
                         k, count, tc, ovf, udf, exp_count(), exp_tc(), exp_ovf(), exp_udf());
            end
        end
        idle();
    endtask

    task automatic test_cascade();
        int n_tc1 = 0;
        idle(); rst = 1; tick(); idle();
        cfg_write(0, 9, 0); tick();
        cfg_write(1, 5, 0); tick(); idle();
        en = '1; up_dn = '1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (tc[1] === 1'b1) n_tc1++;
        end
        idle();
        n_tests++;
        if (dut_cnt(0) !== 0 || dut_cnt(1) !== 0 || n_tc1 != 1) begin
            n_fail++; $display("FAIL cascade_end count0=%0d count1=%0d ch1_wraps=%0d required 0 0 1", dut_cnt(0), dut_cnt(1), n_tc1);
        end
        n_tests++;
        if (count !== exp_count() || ovf !== exp_ovf()) begin
            n_fail++; $display("FAIL cascade_model count=%h ovf=%b required %h %b", count, ovf, exp_count(), exp_ovf());
        end
    endtask

    initial begin
        idle();
`ifdef MULTI_COUNTER_CASCADE_EN
        test_cascade();
`else
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_load_clamp();
        test_cfg_race();
        test_limit_zero();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_counter.md
Name: multi_counter

Overview:
- Parametrised successor to the single 8-bit counter: NUM_CH independent up/down counters with shared WIDTH.
- Each channel has a per-channel modulo limit, a wrap/saturate mode, a one-cycle terminal-count pulse, and sticky overflow/underflow flags.
- Used as the timer/event-count bank feeding status logic; channel configuration is programmed through a small write port.

Parameters:
- WIDTH, 8, bit width of each counter and of each limit.
- NUM_CH, 4, number of channels (1..16).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  NUM_CH  per-channel count enable.
- up_dn  in  NUM_CH  per-channel direction: 1 = up, 0 = down.
- load  in  NUM_CH  per-channel synchronous load strobe.
- load_data  in  NUM_CH*WIDTH  load values; channel i occupies bits [i*WIDTH +: WIDTH].
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  channel selected for the configuration write.
- cfg_limit  in  WIDTH  new modulo limit (terminal value) for the selected channel.
- cfg_mode  in  1  new mode for the selected channel: 0 = WRAP, 1 = SAT.
- ovf_clr  in  NUM_CH  per-channel clear of the sticky ovf/udf flags.
- count  out  NUM_CH*WIDTH  current counts, same packing as load_data.
- tc  out  NUM_CH  registered one-cycle pulse on a terminal event.
- ovf  out  NUM_CH  sticky overflow flag.
- udf  out  NUM_CH  sticky underflow flag.

Behaviour:
- Reset (rst=1 at a clk edge):
  - count=0, tc=0, ovf=0, udf=0.
  - limit[i] = all-ones, mode[i] = WRAP.
  - rst overrides every other input, including in-flight loads and config writes.
- Per-channel priority each cycle: rst > load > (en counting) > hold.
- Load:
  - count <= min(load_data_i, limit_i).
  - No tc pulse; ovf/udf unchanged.
- Up step (en=1, up_dn=1):
  - count < limit: count+1.
  - count >= limit, WRAP: count <= 0, tc=1, ovf set.
  - count >= limit, SAT: count <= limit, tc=1, ovf set.
- Down step (en=1, up_dn=0):
  - count > limit: count <= limit. This is a clamp only; no flag, no tc.
  - count = 0, WRAP: count <= limit, tc=1, udf set.
  - count = 0, SAT: count stays 0, tc=1, udf set.
  - Otherwise: count-1.
- tc timing and repeats:
  - tc is registered: it is high in the cycle after the terminal edge, for exactly one cycle per terminal step.
  - In SAT mode with en held at the terminal value, tc pulses every cycle.
- Flag clear:
  - ovf_clr_i clears both ovf_i and udf_i.
  - Set in the same cycle as ovf_clr wins; the flag stays 1.
- Config writes:
  - cfg_we writes limit/mode of channel cfg_ch; the new values take effect from the next cycle.
  - A write in the same cycle as a count step: the step uses the old limit/mode.
  - cfg_ch >= NUM_CH: the write is ignored.
- limit = 0: the channel is permanently at its terminal value; every enabled step produces tc (count stays 0).
- Arithmetic is unsigned, modulo 2^WIDTH internally; no intermediate value exceeds WIDTH bits.

Optional Feature:
- Macro: MULTI_COUNTER_CASCADE_EN.
- Defined:
  - Channel i (i>=1) advances only when en_i=1 AND channel i-1 has a terminal event in the same cycle. This uses the combinational pre-register event, so the chain is zero-latency.
  - Channel 0 behaves as normal.
  - load still has priority in every channel.
- Undefined: channels are fully independent; no cascade logic is present.

Decomposition:
- Package multi_counter_pkg:
  - mode_e enum {MODE_WRAP=1'b0, MODE_SAT=1'b1}.
  - Default WIDTH/NUM_CH localparams.
  - Function ch_slice index helper.
- Sub-module counter_channel:
  - One channel: count/limit/mode registers, step logic, tc/ovf/udf.
  - Outputs a combinational term_evt for cascading.
  - Top level instantiates it NUM_CH times in a generate loop and decodes cfg writes.

Test Plan:
- Reset: hold rst 2 cycles mid-count (count=0x37) -> all count=0, tc=0, ovf=udf=0; limit reads back 0xFF via wrap at 255.
- Wrap up: ch0 limit=9, WRAP, en=1 up for 12 cycles from 0 -> count 0..9,0,1; tc high exactly once, the cycle after 9->0; ovf=1.
- Saturate down: ch1 SAT, load 2, down 4 cycles -> 1,0,0,0; tc pulses twice (two terminal steps); udf=1; ovf_clr with a concurrent terminal step -> udf stays 1.
- Load clamp and priority: ch2 limit=20, load=1 with load_data=50 and en=1 -> count=20, no tc; next cycle up -> 0 (WRAP), tc=1.
- Config race: cfg_we to ch3 limit=3 in the same cycle ch3 steps 5->6 (old limit 0xFF) -> count=6; next up step -> 0 with ovf set (count > limit); cfg_ch=7 write ignored.
- With MULTI_COUNTER_CASCADE_EN: ch0 limit=9, ch1 limit=5, all en=1 -> ch1 increments only on ch0 9->0; after 60 cycles ch1 has wrapped once and ch0=0, ch1=0.
